// File: rtl/exe_muldiv_stall_unit.sv
// Iterative RV32M multiply/divide unit for the EXE stage. It holds stall_req_EXE while an
// operation is in flight and presents the result for one EX/MEM capture when the stall drops.
module exe_muldiv_stall_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_EXE,
  input  logic [2:0]      funct3_EXE,
  input  logic [XLEN-1:0] rs1_data_EXE,
  input  logic [XLEN-1:0] rs2_data_EXE,
  input  logic            flush_EXE,
  input  logic            hold_EXE,
  output logic            stall_req_EXE,
  output logic            busy_EXE,
  output logic [XLEN-1:0] result_EXE,
  output logic            result_valid_EXE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_start;

  // Shared datapath: r_hi/r_lo are the product halves for multiply, and the
  // partial remainder / shifting dividend-quotient for divide.
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_opb;
  logic [2:0]        r_funct3;
  logic              r_neg_q;
  logic              r_neg_r;

  logic signed [XLEN-1:0] w_opa_s;
  logic signed [XLEN-1:0] w_opb_s;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_neg_q;

  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_dshift;
  logic              w_dfit;
  logic [XLEN-1:0]   w_dsub;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand decode at start: only MULHU, DIVU and REMU treat rs1 as unsigned.
  always_comb begin
    w_opa_s    = $signed(rs1_data_EXE);
    w_opb_s    = $signed(rs2_data_EXE);
    w_a_signed = (funct3_EXE != 3'b011) && (funct3_EXE != 3'b101) && (funct3_EXE != 3'b111);
    w_b_signed = (funct3_EXE == 3'b000) || (funct3_EXE == 3'b001) ||
                 (funct3_EXE == 3'b100) || (funct3_EXE == 3'b110);
    w_sgn_a    = w_a_signed & w_opa_s[XLEN-1];
    w_sgn_b    = w_b_signed & w_opb_s[XLEN-1];
    w_mag_a    = f_cneg(rs1_data_EXE, w_sgn_a);
    w_mag_b    = f_cneg(rs2_data_EXE, w_sgn_b);
    // A zero divisor yields an all-ones quotient regardless of dividend sign.
    if (funct3_EXE[2]) w_neg_q = (w_sgn_a ^ w_sgn_b) & (|rs2_data_EXE);
    else               w_neg_q = w_sgn_a ^ w_sgn_b;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst && op_valid_EXE && !flush_EXE) begin
          w_start     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == C_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!hold_EXE) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_EXE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)                 r_cnt <= '0;
      else if (r_state == S_BUSY)  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stall_req_EXE    = !flush_EXE && (w_start || (r_state == S_BUSY));
  assign busy_EXE         = (r_state != S_IDLE);
  assign result_valid_EXE = (r_state == S_DONE) && !flush_EXE;

  // One iteration per BUSY cycle: shift-add multiply or restoring divide step.
  always_comb begin
    w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    w_dshift = {r_hi, r_lo[XLEN-1]};
    w_dfit   = (w_dshift >= {1'b0, r_opb});
    w_dsub   = w_dshift[XLEN-1:0] - r_opb;
    if (r_funct3[2]) begin
      w_hi_nxt = w_dfit ? w_dsub : w_dshift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_dfit};
    end else begin
      w_hi_nxt = w_madd[XLEN:1];
      w_lo_nxt = {w_madd[0], r_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_hi     <= '0;
      r_lo     <= w_mag_a;
      r_opb    <= w_mag_b;
      r_funct3 <= funct3_EXE;
      r_neg_q  <= w_neg_q;
      r_neg_r  <= w_sgn_a;
    end else if (r_state == S_BUSY) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  // Sign correction of the magnitude result, then funct3 selection.
  always_comb begin
    w_prod = f_cneg2({r_hi, r_lo}, r_neg_q);
    w_quo  = f_cneg(r_lo, r_neg_q);
    w_rem  = f_cneg(r_hi, r_neg_r);
    case (r_funct3)
      3'b000:                 w_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = w_quo;
      default:                w_res = w_rem;
    endcase
    result_EXE = (r_state == S_DONE) ? w_res : '0;
  end

endmodule

// File: tb/tb_exe_muldiv_stall_unit.sv
// Scoreboard bench for exe_muldiv_stall_unit: expected results are queued at issue and
// compared by an independent monitor whenever the unit presents a result.
module tb_exe_muldiv_stall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_EXE;
  logic [2:0]  funct3_EXE;
  logic [31:0] rs1_data_EXE;
  logic [31:0] rs2_data_EXE;
  logic        flush_EXE;
  logic        hold_EXE;
  logic        stall_req_EXE;
  logic        busy_EXE;
  logic [31:0] result_EXE;
  logic        result_valid_EXE;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  exe_muldiv_stall_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .op_valid_EXE     (op_valid_EXE),
    .funct3_EXE       (funct3_EXE),
    .rs1_data_EXE     (rs1_data_EXE),
    .rs2_data_EXE     (rs2_data_EXE),
    .flush_EXE        (flush_EXE),
    .hold_EXE         (hold_EXE),
    .stall_req_EXE    (stall_req_EXE),
    .busy_EXE         (busy_EXE),
    .result_EXE       (result_EXE),
    .result_valid_EXE (result_valid_EXE)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop one expectation per result presentation, compare every valid cycle.
  initial begin
    logic        prev_v;
    logic        have;
    logic [31:0] cur;
    prev_v = 1'b0;
    have   = 1'b0;
    cur    = '0;
    forever begin
      @(negedge clk);
      if (rst && result_valid_EXE) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            have = 1'b0;
            check("spurious_valid", result_valid_EXE, 0);
          end else begin
            have = 1'b1;
            cur  = exp_q.pop_front();
          end
        end
        if (have) check("result", result_EXE, cur);
      end
      prev_v = rst && result_valid_EXE;
    end
  end

  // Issue one op at posedge+1, scramble operands while stalled, then honour hold_n DONE holds.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold_n);
    int sc;
    int vc;
    op_valid_EXE = 1'b1;
    funct3_EXE   = f;
    rs1_data_EXE = a;
    rs2_data_EXE = b;
    exp_q.push_back(exp);
    sc = 0;
    @(negedge clk);
    while (stall_req_EXE && sc < 100) begin
      sc++;
      @(posedge clk); #1;
      rs1_data_EXE = $urandom;
      rs2_data_EXE = $urandom;
      funct3_EXE   = 3'($urandom);
      @(negedge clk);
    end
    check("stall_len", sc, 33);
    vc = 0;
    for (int i = 0; i <= hold_n; i++) begin
      hold_EXE = (i < hold_n);
      if (result_valid_EXE) vc++;
      @(posedge clk); #1;
      if (i < hold_n) @(negedge clk);
    end
    hold_EXE     = 1'b0;
    op_valid_EXE = 1'b0;
    check("valid_len", vc, hold_n + 1);
  endtask

  // Start an op then kill it at BUSY count at_cnt by flush (use_rst=0) or reset (use_rst=1).
  task automatic start_abort(input int at_cnt, input bit use_rst);
    op_valid_EXE = 1'b1;
    funct3_EXE   = 3'b100;
    rs1_data_EXE = $urandom;
    rs2_data_EXE = $urandom;
    @(negedge clk);
    check("abort_start_stall", stall_req_EXE, 1);
    repeat (at_cnt + 1) @(posedge clk);
    #1;
    if (!use_rst) begin
      flush_EXE = 1'b1;
      @(negedge clk);
      check("flush_stall", stall_req_EXE, 0);
      check("flush_valid", result_valid_EXE, 0);
      @(posedge clk); #1;
      flush_EXE    = 1'b0;
      op_valid_EXE = 1'b0;
      @(negedge clk);
      check("flush_busy", busy_EXE, 0);
      check("flush_stall_after", stall_req_EXE, 0);
    end else begin
      rst          = 1'b0;
      op_valid_EXE = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_stall", stall_req_EXE, 0);
      check("rst_busy", busy_EXE, 0);
      check("rst_valid", result_valid_EXE, 0);
      check("rst_result", result_EXE, 0);
      @(posedge clk); #1;
      rst = 1'b1;
    end
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle_busy", busy_EXE, 0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst          = 1'b0;
    op_valid_EXE = 1'b0;
    funct3_EXE   = 3'b000;
    rs1_data_EXE = '0;
    rs2_data_EXE = '0;
    flush_EXE    = 1'b0;
    hold_EXE     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", stall_req_EXE, 0);
    check("reset_busy", busy_EXE, 0);
    check("reset_valid", result_valid_EXE, 0);
    check("reset_result", result_EXE, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op(3'b111, 32'd5,         32'd0,         32'd5,         0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);

    start_abort(10, 1'b0);
    start_abort(20, 1'b1);

    // flush and op_valid together in IDLE must not start anything
    op_valid_EXE = 1'b1;
    flush_EXE    = 1'b1;
    funct3_EXE   = 3'b000;
    @(negedge clk);
    check("idle_flush_stall", stall_req_EXE, 0);
    @(posedge clk); #1;
    op_valid_EXE = 1'b0;
    flush_EXE    = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", busy_EXE, 0);
    @(posedge clk); #1;

    // back-to-back DIVs, first one held for three extra cycles
    run_op(3'b100, 32'd100,        32'd7, 32'd14,         3);
    run_op(3'b100, 32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFF2,  0);

    for (int n = 0; n < 30; n++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, ref_model(f, a, b), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
